// File: rtl/spi_pkg.sv
// spi_pkg: shared definitions for the SPI transfer controller.
//   - register byte offsets on the internal bus (only addr[7:0] decoded)
//   - CTRL and STATUS field positions
//   - sequencing FSM state encoding
package spi_pkg;

  localparam logic [7:0] OFF_CTRL   = 8'h00;
  localparam logic [7:0] OFF_CLKDIV = 8'h04;
  localparam logic [7:0] OFF_TXDATA = 8'h08;
  localparam logic [7:0] OFF_RXDATA = 8'h0C;
  localparam logic [7:0] OFF_STATUS = 8'h10;

  localparam int CTRL_EN       = 0;
  localparam int CTRL_CPOL     = 1;
  localparam int CTRL_CPHA     = 2;
  localparam int CTRL_START    = 3;
  localparam int CTRL_IE       = 4;
  localparam int CTRL_CSSEL_LO = 6;
  localparam int CTRL_CSSEL_HI = 7;

  localparam int STAT_BUSY = 0;
  localparam int STAT_DONE = 1;
  localparam int STAT_OVR  = 2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT,
    ST_HOLD
  } xfer_state_e;

endpackage

// File: rtl/spi_shift_core.sv
// spi_shift_core: SPI bit engine.
// Owns the half-period counter, sclk edge generation, edge/bit counting and
// the TX/RX shift registers. Mode (cpol, cpha) and half-period length are
// captured on load_i so register writes during a transfer cannot disturb it.
//   clk, rst      system clock, synchronous active-high reset
//   load_i        start of transfer: capture tx/mode/h, restart counters
//   shift_i       high while the sequencer is in SHIFT (edges allowed)
//   tx_i          frame to send, MSB first
//   cpol_i/cpha_i SPI mode for this transfer
//   h_i           half-period length minus one, in clk cycles
//   miso_i        serial data in
//   sclk_o        SPI clock (idle level = captured cpol)
//   mosi_o        serial data out (MSB of TX shift register)
//   rx_o          received frame
//   tick_o        last cycle of the current half-period
//   last_edge_o   final sclk edge of the frame is happening this cycle
module spi_shift_core #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic              shift_i,
  input  logic [DATA_W-1:0] tx_i,
  input  logic              cpol_i,
  input  logic              cpha_i,
  input  logic [15:0]       h_i,
  input  logic              miso_i,
  output logic              sclk_o,
  output logic              mosi_o,
  output logic [DATA_W-1:0] rx_o,
  output logic              tick_o,
  output logic              last_edge_o
);

  localparam int ECW = $clog2(2 * DATA_W);

  logic [15:0]       hcnt_q;
  logic [15:0]       h_q;
  logic              cpha_q;
  logic              sclk_q;
  logic [ECW-1:0]    edge_q;   // sclk edges already produced in this frame
  logic [DATA_W-1:0] tx_sr_q;
  logic [DATA_W-1:0] rx_sr_q;

  logic edge_now;
  logic leading;
  logic sample_now;
  logic drive_now;

  assign tick_o      = (hcnt_q == h_q);
  assign edge_now    = shift_i & tick_o;
  // Edges 1,3,5.. (edge_q even before the edge) are the leading edges.
  assign leading     = ~edge_q[0];
  assign sample_now  = edge_now & (leading ^ cpha_q);
  // MSB is already on mosi after load, so the first CPHA=1 drive edge has
  // nothing new to present and must not shift.
  assign drive_now   = edge_now & ~(leading ^ cpha_q) & (edge_q != '0);
  assign last_edge_o = edge_now & (edge_q == ECW'(2 * DATA_W - 1));

  assign sclk_o = sclk_q;
  assign mosi_o = tx_sr_q[DATA_W-1];
  assign rx_o   = rx_sr_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      hcnt_q  <= '0;
      h_q     <= '0;
      cpha_q  <= 1'b0;
      sclk_q  <= 1'b0;
      edge_q  <= '0;
      tx_sr_q <= '0;
      rx_sr_q <= '0;
    end else if (load_i) begin
      hcnt_q  <= '0;
      h_q     <= h_i;
      cpha_q  <= cpha_i;
      sclk_q  <= cpol_i;
      edge_q  <= '0;
      tx_sr_q <= tx_i;
      rx_sr_q <= '0;
    end else begin
      hcnt_q <= tick_o ? '0 : hcnt_q + 16'd1;
      if (edge_now) begin
        sclk_q <= ~sclk_q;
        edge_q <= edge_q + ECW'(1);
      end
      if (sample_now) rx_sr_q <= {rx_sr_q[DATA_W-2:0], miso_i};
      if (drive_now)  tx_sr_q <= {tx_sr_q[DATA_W-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/spi_xfer_ctrl.sv
// spi_xfer_ctrl: register file and SPI transfer sequencer.
// Decodes the internal bus into CTRL/CLKDIV/TXDATA/RXDATA/STATUS, acks each
// held request exactly once, flags bad accesses, and sequences one SPI frame
// (IDLE -> SETUP -> SHIFT -> HOLD) per START.
//   clk, rst                  system clock, synchronous active-high reset
//   waddr/wdata/wr_en, wack   write request (held until wack), ack pulse
//   waddrerr                  write error, valid with wack
//   raddr/rd_en, rack, rdata  read request (held until rack), ack + data
//   raddrerr                  read error, valid with rack
//   sclk, mosi, miso, cs_n    SPI master pins
//   irq                       level interrupt, DONE & IE
module spi_xfer_ctrl
  import spi_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int NUM_CS = 1,
  parameter int AW     = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [AW-1:0]     waddr,
  input  logic [AW-1:0]     raddr,
  input  logic [31:0]       wdata,
  input  logic              wr_en,
  input  logic              rd_en,
  output logic [31:0]       rdata,
  output logic              wack,
  output logic              rack,
  output logic              waddrerr,
  output logic              raddrerr,
  output logic              sclk,
  output logic              mosi,
  input  logic              miso,
  output logic [NUM_CS-1:0] cs_n,
  output logic              irq
);

  xfer_state_e state_q, state_d;

  logic              en_q, cpol_q, cpha_q, ie_q;
  logic [1:0]        cssel_q;
  logic [15:0]       clkdiv_q;
  logic [DATA_W-1:0] txdata_q, rxdata_q;
  logic              done_q, done_d, ovr_q, ovr_d;
  logic [NUM_CS-1:0] cs_n_q, cs_n_d;
  logic              wack_q, rack_q, waddrerr_q, raddrerr_q;
  logic [31:0]       rdata_q;

  logic [7:0]  woff, roff;
  logic        wr_fire, rd_fire, wr_err, rd_err, wr_ok;
  logic [31:0] rd_val;
  logic        wr_ctrl, wr_status, start_req, start_go, abort, busy, xfer_done;
  logic        core_sclk, core_mosi, core_tick, core_last;
  logic [DATA_W-1:0] core_rx;
  logic        unused_bits;

  // Only the low address byte is decoded; the rest is deliberately ignored.
  assign unused_bits = ^{waddr, raddr, wdata};

  assign woff    = waddr[7:0];
  assign roff    = raddr[7:0];
  assign wr_fire = wr_en & ~wack_q;
  assign rd_fire = rd_en & ~rack_q;
  assign wr_ok   = wr_fire & ~wr_err;
  assign busy    = (state_q != ST_IDLE);

  assign wr_ctrl   = wr_ok & (woff == OFF_CTRL);
  assign wr_status = wr_ok & (woff == OFF_STATUS);
  assign start_req = wr_ctrl & wdata[CTRL_START];
  assign start_go  = start_req & wdata[CTRL_EN] & ~busy;
  assign abort     = wr_ctrl & ~wdata[CTRL_EN] & busy;

  // Unaligned offsets never match a case item, so they fall into default.
  // NOTE: every always_comb output gets a value before any branch, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    wr_err = 1'b0;
    case (woff)
      OFF_CTRL:                           wr_err = int'(wdata[CTRL_CSSEL_HI:CTRL_CSSEL_LO]) >= NUM_CS;
      OFF_CLKDIV, OFF_TXDATA, OFF_STATUS: wr_err = 1'b0;
      default:                            wr_err = 1'b1;  // RXDATA is read-only
    endcase
  end

  always_comb begin
    rd_val = '0;
    rd_err = 1'b0;
    case (roff)
      OFF_CTRL:   rd_val = {24'd0, cssel_q, 1'b0, ie_q, 1'b0, cpha_q, cpol_q, en_q};
      OFF_CLKDIV: rd_val = {16'd0, clkdiv_q};
      OFF_TXDATA: rd_val = 32'(txdata_q);
      OFF_RXDATA: rd_val = 32'(rxdata_q);
      OFF_STATUS: rd_val = {29'd0, ovr_q, done_q, busy};
      default:    rd_err = 1'b1;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    xfer_done = 1'b0;
    case (state_q)
      ST_IDLE:  if (start_go)  state_d = ST_SETUP;
      ST_SETUP: if (core_tick) state_d = ST_SHIFT;
      ST_SHIFT: if (core_last) state_d = ST_HOLD;
      ST_HOLD: begin
        if (core_tick) begin
          state_d   = ST_IDLE;
          xfer_done = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (abort) begin
      state_d   = ST_IDLE;
      xfer_done = 1'b0;
    end
  end

  always_comb begin
    cs_n_d = cs_n_q;
    if (start_go) begin
      for (int i = 0; i < NUM_CS; i++)
        cs_n_d[i] = (i != int'(wdata[CTRL_CSSEL_HI:CTRL_CSSEL_LO]));
    end else if (xfer_done || abort) begin
      cs_n_d = '1;
    end
  end

  // Completion set is applied after the W1C clear so a collision keeps DONE.
  always_comb begin
    done_d = done_q;
    ovr_d  = ovr_q;
    if (wr_status && wdata[STAT_DONE]) done_d = 1'b0;
    if (wr_status && wdata[STAT_OVR])  ovr_d  = 1'b0;
    if (xfer_done)                     done_d = 1'b1;
    if (start_req && busy)             ovr_d  = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      en_q       <= 1'b0;
      cpol_q     <= 1'b0;
      cpha_q     <= 1'b0;
      ie_q       <= 1'b0;
      cssel_q    <= '0;
      clkdiv_q   <= '0;
      txdata_q   <= '0;
      rxdata_q   <= '0;
      done_q     <= 1'b0;
      ovr_q      <= 1'b0;
      cs_n_q     <= '1;
      wack_q     <= 1'b0;
      rack_q     <= 1'b0;
      waddrerr_q <= 1'b0;
      raddrerr_q <= 1'b0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      done_q     <= done_d;
      ovr_q      <= ovr_d;
      cs_n_q     <= cs_n_d;
      wack_q     <= wr_fire;
      waddrerr_q <= wr_fire & wr_err;
      rack_q     <= rd_fire;
      raddrerr_q <= rd_fire & rd_err;
      rdata_q    <= rd_fire ? rd_val : '0;
      if (wr_ctrl) begin
        en_q    <= wdata[CTRL_EN];
        cpol_q  <= wdata[CTRL_CPOL];
        cpha_q  <= wdata[CTRL_CPHA];
        ie_q    <= wdata[CTRL_IE];
        cssel_q <= wdata[CTRL_CSSEL_HI:CTRL_CSSEL_LO];
      end
      if (wr_ok && woff == OFF_CLKDIV) clkdiv_q <= wdata[15:0];
      if (wr_ok && woff == OFF_TXDATA) txdata_q <= wdata[DATA_W-1:0];
      if (xfer_done)                   rxdata_q <= core_rx;
    end
  end

  // Mode bits come from the START write itself so a combined mode+START
  // write launches with the new mode.
  spi_shift_core #(.DATA_W(DATA_W)) u_core (
    .clk        (clk),
    .rst        (rst),
    .load_i     (start_go),
    .shift_i    (state_q == ST_SHIFT),
    .tx_i       (txdata_q),
    .cpol_i     (wdata[CTRL_CPOL]),
    .cpha_i     (wdata[CTRL_CPHA]),
    .h_i        (clkdiv_q),
    .miso_i     (miso),
    .sclk_o     (core_sclk),
    .mosi_o     (core_mosi),
    .rx_o       (core_rx),
    .tick_o     (core_tick),
    .last_edge_o(core_last)
  );

  assign sclk     = busy ? core_sclk : cpol_q;
  assign mosi     = busy ? core_mosi : 1'b0;
  assign cs_n     = cs_n_q;
  assign irq      = done_q & ie_q;
  assign wack     = wack_q;
  assign rack     = rack_q;
  assign waddrerr = waddrerr_q;
  assign raddrerr = raddrerr_q;
  assign rdata    = rdata_q;

endmodule

// File: tb/tb_spi_xfer_ctrl.sv
// tb_spi_xfer_ctrl: directed self-checking bench for spi_xfer_ctrl with a
// simple SPI slave model that returns slave_tx and captures mosi.
module tb_spi_xfer_ctrl;
  import spi_pkg::*;

  localparam int DATA_W = 8;
  localparam int NUM_CS = 1;
  localparam int AW     = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic [AW-1:0]     waddr, raddr;
  logic [31:0]       wdata, rdata;
  logic              wr_en, rd_en, wack, rack, waddrerr, raddrerr;
  logic              sclk, mosi, miso, irq;
  logic [NUM_CS-1:0] cs_n;

  int n_tests = 0;
  int n_fail  = 0;

  spi_xfer_ctrl #(.DATA_W(DATA_W), .NUM_CS(NUM_CS), .AW(AW)) dut (
    .clk(clk), .rst(rst), .waddr(waddr), .raddr(raddr), .wdata(wdata),
    .wr_en(wr_en), .rd_en(rd_en), .rdata(rdata), .wack(wack), .rack(rack),
    .waddrerr(waddrerr), .raddrerr(raddrerr), .sclk(sclk), .mosi(mosi),
    .miso(miso), .cs_n(cs_n), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Slave model: CPHA=0 presents MSB at cs_n fall and changes on trailing
  // edges; CPHA=1 changes on leading edges. Captures mosi on the other edge.
  logic [7:0] slave_tx = 8'h3C;
  logic [7:0] slave_rx;
  logic       sl_cpha = 1'b0;
  int         sl_ptr, sl_edges, sl_rises;

  always @(negedge cs_n[0]) begin
    sl_edges = 0;
    sl_rises = 0;
    slave_rx = '0;
    if (sl_cpha) begin
      miso   = 1'b0;
      sl_ptr = 7;
    end else begin
      miso   = slave_tx[7];
      sl_ptr = 6;
    end
  end

  always @(sclk) begin
    if (cs_n[0] == 1'b0) begin
      logic lead;
      sl_edges++;
      if (sclk == 1'b1) sl_rises++;
      lead = (sl_edges % 2 == 1);
      if (lead != sl_cpha) slave_rx = {slave_rx[6:0], mosi};
      else if (sl_ptr >= 0) begin
        miso = slave_tx[sl_ptr];
        sl_ptr--;
      end
    end
  end

  // All bus tasks are entered and left on a falling clock edge.
  task automatic bus_write(input logic [7:0] addr, input logic [31:0] data, output logic err);
    int n = 0;
    waddr = {24'd0, addr};
    wdata = data;
    wr_en = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (!wack && n < 8);
    if (!wack) check("wack timeout", 32'(wack), 32'd1);
    err   = waddrerr;
    wr_en = 1'b0;
  endtask

  task automatic bus_read(input logic [7:0] addr, output logic [31:0] data,
                          output logic err, output int lat);
    lat   = 0;
    raddr = {24'd0, addr};
    rd_en = 1'b1;
    do begin
      @(negedge clk);
      lat++;
    end while (!rack && lat < 8);
    if (!rack) check("rack timeout", 32'(rack), 32'd1);
    data  = rdata;
    err   = raddrerr;
    rd_en = 1'b0;
  endtask

  task automatic read_chk(input string tag, input logic [7:0] addr, input logic [31:0] exp);
    logic [31:0] d;
    logic        e;
    int          l;
    bus_read(addr, d, e, l);
    check({tag, " data"}, d, exp);
    check({tag, " err"}, 32'(e), 32'd0);
  endtask

  task automatic wait_cs_high(output int cyc);
    cyc = 0;
    while (cs_n[0] == 1'b0 && cyc < 1000) begin
      cyc++;
      @(negedge clk);
    end
    if (cs_n[0] == 1'b0) check("cs_n release timeout", 32'(cs_n[0]), 32'd1);
  endtask

  task automatic run_xfer(input logic cpol, input logic cpha, input string tag);
    logic        e;
    int          cyc;
    logic [31:0] c;
    c = 32'h1 | (32'(cpol) << CTRL_CPOL) | (32'(cpha) << CTRL_CPHA);
    sl_cpha = cpha;
    bus_write(OFF_CTRL, c, e);
    check({tag, " idle sclk"}, 32'(sclk), 32'(cpol));
    bus_write(OFF_CTRL, c | (32'h1 << CTRL_START), e);
    check({tag, " start err"}, 32'(e), 32'd0);
    wait_cs_high(cyc);
    check({tag, " cs_n low cycles"}, 32'(cyc), 32'd36);
    check({tag, " sclk after"}, 32'(sclk), 32'(cpol));
    check({tag, " mosi bits"}, 32'(slave_rx), 32'hA5);
    check({tag, " sclk rises"}, 32'(sl_rises), 32'd8);
    read_chk({tag, " RXDATA"}, OFF_RXDATA, 32'h3C);
    read_chk({tag, " STATUS"}, OFF_STATUS, 32'h2);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] d;
    logic        e;
    int          lat, cyc;

    rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; miso = 1'b0;
    waddr = '0; raddr = '0; wdata = '0;
    repeat (3) @(negedge clk);
    check("rst cs_n", 32'(cs_n), 32'h1);
    check("rst sclk", 32'(sclk), 32'd0);
    check("rst mosi", 32'(mosi), 32'd0);
    check("rst acks", {30'd0, wack, rack}, 32'd0);
    check("rst irq", 32'(irq), 32'd0);
    check("rst rdata", rdata, 32'd0);
    rst = 1'b0;

    // Register access and error decode
    bus_write(OFF_CLKDIV, 32'h3, e);
    check("CLKDIV wr err", 32'(e), 32'd0);
    bus_read(OFF_CLKDIV, d, e, lat);
    check("CLKDIV rd data", d, 32'h3);
    check("CLKDIV rd err", 32'(e), 32'd0);
    check("rack latency", 32'(lat), 32'd1);
    bus_read(8'h14, d, e, lat);
    check("unmapped rd err", 32'(e), 32'd1);
    check("unmapped rd data", d, 32'd0);
    bus_read(8'h02, d, e, lat);
    check("unaligned rd err", 32'(e), 32'd1);
    bus_write(OFF_RXDATA, 32'h55, e);
    check("RXDATA wr err", 32'(e), 32'd1);
    read_chk("RXDATA unchanged", OFF_RXDATA, 32'h0);
    bus_write(OFF_CTRL, 32'h41, e);
    check("CSSEL range err", 32'(e), 32'd1);
    read_chk("CTRL after bad wr", OFF_CTRL, 32'h0);

    // Transfers in all four modes
    bus_write(OFF_CLKDIV, 32'h1, e);
    bus_write(OFF_TXDATA, 32'hA5, e);
    slave_tx = 8'h3C;
    run_xfer(1'b0, 1'b0, "mode0");
    run_xfer(1'b0, 1'b1, "mode1");
    run_xfer(1'b1, 1'b0, "mode2");
    run_xfer(1'b1, 1'b1, "mode3");

    // Writes while busy: START sets OVR, TXDATA change waits for next frame
    sl_cpha = 1'b0;
    bus_write(OFF_STATUS, 32'h6, e);
    bus_write(OFF_CTRL, 32'h1, e);
    bus_write(OFF_CTRL, 32'h9, e);
    bus_write(OFF_CTRL, 32'h9, e);
    check("busy START err", 32'(e), 32'd0);
    bus_write(OFF_TXDATA, 32'hFF, e);
    wait_cs_high(cyc);
    check("busy inflight mosi", 32'(slave_rx), 32'hA5);
    read_chk("busy STATUS ovr", OFF_STATUS, 32'h6);
    read_chk("busy RXDATA", OFF_RXDATA, 32'h3C);
    bus_write(OFF_STATUS, 32'h6, e);
    bus_write(OFF_CTRL, 32'h9, e);
    wait_cs_high(cyc);
    check("next frame mosi", 32'(slave_rx), 32'hFF);
    bus_write(OFF_STATUS, 32'h2, e);

    // Abort by clearing EN at SHIFT half-period 5
    slave_tx = 8'h5A;
    bus_write(OFF_CTRL, 32'h9, e);
    repeat (9) @(negedge clk);
    bus_write(OFF_CTRL, 32'h0, e);
    check("abort cs_n", 32'(cs_n), 32'h1);
    check("abort sclk", 32'(sclk), 32'd0);
    read_chk("abort STATUS", OFF_STATUS, 32'h0);
    read_chk("abort RXDATA", OFF_RXDATA, 32'h3C);
    repeat (40) @(negedge clk);
    check("abort cs_n stays", 32'(cs_n), 32'h1);
    read_chk("abort no DONE", OFF_STATUS, 32'h0);

    // Reset in the middle of SHIFT
    bus_write(OFF_CTRL, 32'h1, e);
    bus_write(OFF_CTRL, 32'h9, e);
    repeat (10) @(negedge clk);
    check("pre-reset cs_n low", 32'(cs_n), 32'h0);
    rst = 1'b1;
    @(negedge clk);
    check("mid rst cs_n", 32'(cs_n), 32'h1);
    check("mid rst sclk", 32'(sclk), 32'd0);
    check("mid rst mosi", 32'(mosi), 32'd0);
    check("mid rst irq", 32'(irq), 32'd0);
    rst = 1'b0;
    read_chk("post rst CTRL", OFF_CTRL, 32'h0);
    read_chk("post rst CLKDIV", OFF_CLKDIV, 32'h0);
    read_chk("post rst STATUS", OFF_STATUS, 32'h0);
    read_chk("post rst RXDATA", OFF_RXDATA, 32'h0);

    // Interrupt and DONE set/clear collision
    slave_tx = 8'h3C;
    bus_write(OFF_CLKDIV, 32'h1, e);
    bus_write(OFF_TXDATA, 32'hA5, e);
    bus_write(OFF_CTRL, 32'h11, e);
    bus_write(OFF_CTRL, 32'h19, e);
    wait_cs_high(cyc);
    check("irq xfer cycles", 32'(cyc), 32'd36);
    check("irq on done", 32'(irq), 32'd1);
    bus_write(OFF_STATUS, 32'h2, e);
    check("irq after W1C", 32'(irq), 32'd0);
    read_chk("DONE cleared", OFF_STATUS, 32'h0);
    bus_write(OFF_CTRL, 32'h19, e);
    repeat (35) @(negedge clk);
    bus_write(OFF_STATUS, 32'h2, e);
    check("collide cs_n", 32'(cs_n), 32'h1);
    check("collide irq", 32'(irq), 32'd1);
    read_chk("collide DONE kept", OFF_STATUS, 32'h2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
